// File: rtl/mul_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_arb_pkg                                                          |
// | Shared widths and FSM encoding for the multiplier arbiter.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mul_arb_pkg;

  localparam int N_DEF = 32;
  localparam int P_DEF = 2 * N_DEF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CLR    = ST_CLR,
    LAUNCH = ST_LAUNCH,
    WAIT   = ST_WAIT,
    RESP   = ST_RESP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_32u_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at or above ptr.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int              cand;
  logic [NREQ-1:0] shifted;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(ptr) + k) % NREQ;
      shifted = req >> cand;
      if (!any && shifted[0]) begin
        any   = 1'b1;
        idx   = IDW'(cand);
        grant = {{(NREQ-1){1'b0}}, 1'b1} << cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_32u_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_32u_arbiter                                                      |
// | Round-robin sharing of one multi-cycle multiplier among NREQ         |
// | requesters. Optional watchdog enabled by macro MUL_TIMEOUT_EN.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mul_32u_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int N       = N_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [2*N-1:0]    resp_p,
  output logic              resp_err,
  output logic              mul_rst,
  output logic [N-1:0]      mul_x,
  output logic [N-1:0]      mul_y,
  output logic              mul_in_valid,
  input  logic [2*N-1:0]    mul_p,
  input  logic              mul_out_valid
);

  if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mul_32u_arbiter: illegal parameter combination");
  end

  state_t          state;
  state_t          state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  ptr_nx;
  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            timeout_hit;
  logic            wait_done;
  logic [N-1:0]    x_slice [NREQ];
  logic [N-1:0]    y_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign x_slice[i] = req_x[i*N +: N];
    assign y_slice[i] = req_y[i*N +: N];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Grant is visible only in IDLE and never while reset is being applied.
  assign req_ready    = (state == IDLE && !rst) ? arb_grant : '0;
  assign mul_rst      = (state == CLR);
  assign mul_in_valid = (state == LAUNCH);
  assign resp_valid   = (state == RESP);
  assign wait_done    = (state == WAIT) && (mul_out_valid || timeout_hit);
  assign ptr_nx       = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_any) state_nx = CLR;
      CLR:     state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (wait_done) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      mul_x   <= '0;
      mul_y   <= '0;
      resp_id <= '0;
      resp_p  <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        mul_x   <= x_slice[arb_idx];
        mul_y   <= y_slice[arb_idx];
        resp_id <= arb_idx;
        rr_ptr  <= ptr_nx;
      end
      // A real result beats a simultaneous timeout.
      if (wait_done) begin
        resp_p <= mul_out_valid ? mul_p : '0;
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wd_cnt <= '0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wait_done) begin
        err_q <= !mul_out_valid;
      end
    end
  end

  assign timeout_hit = (state == WAIT) && (wd_cnt == TW'(TIMEOUT - 1));
  assign resp_err    = err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_32u_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_32u_arbiter                                                   |
// | Directed scoreboard bench with a sticky-out_valid multiplier stub.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mul_32u_arbiter;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_x = '0;
  logic [127:0] req_y = '0;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [1:0]   resp_id;
  logic [63:0]  resp_p;
  logic         resp_err;
  logic         mul_rst;
  logic [31:0]  mul_x;
  logic [31:0]  mul_y;
  logic         mul_in_valid;
  logic [63:0]  mul_p;
  logic         mul_out_valid;

  int checks = 0;
  int errors = 0;
  int n_mrst = 0;
  int n_miv  = 0;

  int          gq[$];
  logic [65:0] rq[$];

  always #5 clk = ~clk;

  mul_32u_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_p        (resp_p),
    .resp_err      (resp_err),
    .mul_rst       (mul_rst),
    .mul_x         (mul_x),
    .mul_y         (mul_y),
    .mul_in_valid  (mul_in_valid),
    .mul_p         (mul_p),
    .mul_out_valid (mul_out_valid)
  );

  // Multiplier stub: out_valid rises LAT cycles after in_valid and stays high until mul_rst.
  logic [LAT-1:0] pipe  = '0;
  logic           stick = 1'b0;
  logic [63:0]    stub_p = '0;
  assign mul_out_valid = stick | pipe[LAT-1];
  assign mul_p         = stub_p;

  always @(posedge clk) begin
    if (mul_rst) begin
      pipe  <= '0;
      stick <= 1'b0;
    end else begin
      pipe  <= {pipe[LAT-2:0], mul_in_valid};
      stick <= mul_out_valid;
      if (mul_in_valid) stub_p <= {32'b0, mul_x} * {32'b0, mul_y};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 4'b0000) begin
        if (gq.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          logic [3:0] m;
          m = 4'b0001 << gq.pop_front();
          chk("grant_onehot", 64'(req_ready), 64'(m));
        end
      end
      if (mul_rst) n_mrst++;
      if (mul_in_valid) n_miv++;
      if (resp_valid && resp_ready) begin
        if (rq.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          logic [65:0] e;
          e = rq.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e[65:64]));
          chk("resp_p", resp_p, e[63:0]);
          chk("resp_err", 64'(resp_err), 64'd0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
  endtask

  task automatic expect_op(input int id, input logic [63:0] p);
    gq.push_back(id);
    rq.push_back({2'(id), p});
  endtask

  task automatic wait_grant(input logic [3:0] drop);
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("wait_grant");
    @(posedge clk);
    #1;
    req_valid = req_valid & ~drop;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && gq.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_now("drain");
    cyc(2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
    chk({tag, "_resp_p"}, resp_p, 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_mul_rst"}, 64'(mul_rst), 64'd0);
    chk({tag, "_mul_x"}, 64'(mul_x), 64'd0);
    chk({tag, "_mul_y"}, 64'(mul_y), 64'd0);
    chk({tag, "_mul_in_valid"}, 64'(mul_in_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_rst, k_iv, k_rv;
    bit seen;

    // Reset state
    cyc(3);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2);

    // Single request with grant-to-response timing
    set_req(0, 32'h3, 32'h5);
    expect_op(0, 64'h0000_0000_0000_000F);
    req_valid = 4'b0001;
    wait_grant(4'b0001);
    k_rst = -1; k_iv = -1; k_rv = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mul_rst && k_rst < 0) k_rst = k;
      if (mul_in_valid && k_iv < 0) k_iv = k;
      if (resp_valid) begin
        k_rv = k;
        break;
      end
    end
    chk("t1_clr_cycle", 64'(k_rst), 64'd1);
    chk("t1_launch_cycle", 64'(k_iv), 64'd2);
    chk("t1_latency", 64'(k_rv), 64'(3 + LAT));
    drain();

    // Full-width product on requester 2
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_op(2, 64'hFFFF_FFFE_0000_0001);
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    drain();

    // Round-robin with all requesters valid, starting from a fresh pointer
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'h10);
    expect_op(0, 64'h10);
    expect_op(1, 64'h20);
    expect_op(2, 64'h30);
    expect_op(3, 64'h40);
    expect_op(0, 64'h10);
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) wait_grant(4'b0000);
    wait_grant(4'b1111);
    drain();

    // Backpressure with another requester waiting
    resp_ready = 1'b0;
    set_req(1, 32'h7, 32'h9);
    set_req(3, 32'h2, 32'h21);
    expect_op(1, 64'h3F);
    expect_op(3, 64'h42);
    req_valid = 4'b1010;
    wait_grant(4'b0010);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("bp_resp_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_id", 64'(resp_id), 64'd1);
      chk("bp_resp_p", resp_p, 64'h3F);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_mul_rst", 64'(mul_rst), 64'd0);
      chk("bp_mul_in_valid", 64'(mul_in_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_grant(4'b1000);
    drain();

    // Reset two cycles after launch: no response, then a clean operation
    set_req(0, 32'h1234, 32'h10);
    gq.push_back(0);
    req_valid = 4'b0001;
    wait_grant(4'b0001);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_in_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("rst_launch");
    cyc(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    cyc(15);
    chk("midrst_no_resp_valid", 64'(resp_valid), 64'd0);
    set_req(2, 32'h100, 32'h100);
    expect_op(2, 64'h1_0000);
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    drain();

    chk("total_mul_rst_pulses", 64'(n_mrst), 64'd11);
    chk("total_mul_in_valid_pulses", 64'(n_miv), 64'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
